// File: rtl/control_fsm_if.sv
// Signal bundle between the multi-cycle control FSM and the CPU datapath/memory port.
// The FSM takes the master modport; the datapath/memory side takes the slave modport.
interface control_fsm_if #(
   parameter int OPCODE_W = 5,
   parameter int ALU_OP_W = 3,
   parameter int CNT_W    = 16
);
   logic [OPCODE_W-1:0] opcode;
   logic                zero_flag;
   logic                mem_ready;
   logic                ir_load;
   logic                pc_inc;
   logic                pc_load;
   logic                mem_req;
   logic                mem_we;
   logic                reg_write;
   logic [ALU_OP_W-1:0] alu_op;
   logic                retire;
   logic [CNT_W-1:0]    instret;
   logic                halted;
   logic                illegal;
   logic [2:0]          state;

   modport master (
      input  opcode, zero_flag, mem_ready,
      output ir_load, pc_inc, pc_load, mem_req, mem_we, reg_write,
             alu_op, retire, instret, halted, illegal, state
   );

   modport slave (
      output opcode, zero_flag, mem_ready,
      input  ir_load, pc_inc, pc_load, mem_req, mem_we, reg_write,
             alu_op, retire, instret, halted, illegal, state
   );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the 19-bit CPU,
// with memory-ready handshake, branches, HALT, illegal-opcode trap and retire counter.
module control_fsm #(
   parameter int OPCODE_W = 5,
   parameter int ALU_OP_W = 3,
   parameter int CNT_W    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   control_fsm_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6
   } state_t;

   localparam logic [4:0] OP_LOAD  = 5'b01000;
   localparam logic [4:0] OP_STORE = 5'b01001;
   localparam logic [4:0] OP_JMP   = 5'b01010;
   localparam logic [4:0] OP_BEQ   = 5'b01011;
   localparam logic [4:0] OP_BNE   = 5'b01100;
   localparam logic [4:0] OP_NOP   = 5'b01101;
   localparam logic [4:0] OP_HALT  = 5'b01110;

   state_t           state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q;

   logic       ir_load, pc_inc, pc_load, mem_req, mem_we, reg_write, retire, halted;
   logic [2:0] alu3;
   logic       is_alu_q;

   // Legal only when every bit above the 5-bit field is zero and the code is in the map.
   function automatic logic legal_op(input logic [OPCODE_W-1:0] opc);
      return ((opc >> 5) == '0) && (opc[4:0] <= OP_HALT);
   endfunction

   assign is_alu_q = (op_q[4:3] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      halted    = 1'b0;
      alu3      = 3'b000;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            op_d = bus.opcode[4:0];
            if (!legal_op(bus.opcode)) begin
               illegal_d = 1'b1;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end else if (bus.opcode[4:0] == OP_HALT) begin
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_EXECUTE;
            end
         end

         S_EXECUTE: begin
            if (is_alu_q) begin
               alu3    = op_q[2:0];
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_FETCH;
               case (op_q)
                  OP_LOAD, OP_STORE: state_d = S_MEMORY;
                  OP_JMP: begin
                     pc_load = 1'b1;
                     retire  = 1'b1;
                  end
                  OP_BEQ: begin
                     alu3    = 3'b001;
                     pc_load = bus.zero_flag;
                     retire  = 1'b1;
                  end
                  OP_BNE: begin
                     alu3    = 3'b001;
                     pc_load = ~bus.zero_flag;
                     retire  = 1'b1;
                  end
                  OP_NOP:  retire = 1'b1;
                  default: retire = 1'b0;
               endcase
            end
         end

         // Request and write qualifier are held for the whole wait.
         S_MEMORY: begin
            mem_req = 1'b1;
            mem_we  = (op_q == OP_STORE);
            if (bus.mem_ready) begin
               if (op_q == OP_STORE) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end
         end

         S_WRITEBACK: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            if (is_alu_q) alu3 = op_q[2:0];
            state_d   = S_FETCH;
         end

         S_HALT: halted = 1'b1;

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.ir_load   = ir_load;
   assign bus.pc_inc    = pc_inc;
   assign bus.pc_load   = pc_load;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.reg_write = reg_write;
   assign bus.alu_op    = ALU_OP_W'(alu3);
   assign bus.retire    = retire;
   assign bus.instret   = instret_q;
   assign bus.halted    = halted;
   assign bus.illegal   = illegal_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: a vector table of instructions run through a scoreboard,
// followed by hand-written HALT, reset-pulse and reset-during-STORE-wait sequences.
module tb_control_fsm;
   localparam int OW = 6;
   localparam int AW = 4;
   localparam int CW = 4;
   localparam int N  = 19;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   control_fsm_if #(.OPCODE_W(OW), .ALU_OP_W(AW), .CNT_W(CW)) bus ();

   control_fsm #(.OPCODE_W(OW), .ALU_OP_W(AW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [OW-1:0] op;
      logic          zf;
      int            wf;      // mem_ready-low cycles during FETCH
      int            wm;      // mem_ready-low cycles during MEMORY
      int            cyc;     // cycles from first FETCH cycle to retire, inclusive
      int            rw;
      int            pcl;
      int            mreq;
      int            we;
      logic [AW-1:0] alu_ex;
      logic [AW-1:0] alu_wb;
      logic [7:0]    smask;   // set of states visited
      logic          sets_ill;
   } vec_t;

   typedef struct {
      int            cyc;
      int            rw;
      int            pcl;
      int            mreq;
      int            we;
      int            irl;
      int            pci;
      logic [AW-1:0] alu_ex;
      logic [AW-1:0] alu_wb;
      logic [7:0]    smask;
   } obs_t;

   vec_t vecs[N];
   vec_t sb_q[$];
   int   n_tests;
   int   n_fail;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            idx;
      int            wait_cnt;
      int            bad;
      int            found;
      int            cnt;
      obs_t          ob;
      vec_t          ev;
      logic [CW-1:0] exp_cnt;
      logic          ill_seen;

      n_tests = 0;
      n_fail  = 0;
      //          op     zf  wf wm cyc rw pcl mreq we alu_ex alu_wb smask  ill
      vecs[0]  = '{6'h00, 1'b0, 0, 0, 4, 1, 0, 1, 0, 4'd0, 4'd0, 8'h2E, 1'b0}; // ADD
      vecs[1]  = '{6'h01, 1'b0, 2, 0, 6, 1, 0, 3, 0, 4'd1, 4'd1, 8'h2E, 1'b0}; // SUB, fetch wait
      vecs[2]  = '{6'h04, 1'b1, 0, 0, 4, 1, 0, 1, 0, 4'd4, 4'd4, 8'h2E, 1'b0}; // XOR
      vecs[3]  = '{6'h07, 1'b0, 0, 0, 4, 1, 0, 1, 0, 4'd7, 4'd7, 8'h2E, 1'b0}; // SHR
      vecs[4]  = '{6'h08, 1'b0, 0, 3, 8, 1, 0, 5, 0, 4'd0, 4'd0, 8'h3E, 1'b0}; // LOAD, 3 waits
      vecs[5]  = '{6'h09, 1'b0, 1, 2, 7, 0, 0, 5, 3, 4'd0, 4'd0, 8'h1E, 1'b0}; // STORE
      vecs[6]  = '{6'h0A, 1'b0, 0, 0, 3, 0, 1, 1, 0, 4'd0, 4'd0, 8'h0E, 1'b0}; // JMP
      vecs[7]  = '{6'h0B, 1'b1, 0, 0, 3, 0, 1, 1, 0, 4'd1, 4'd0, 8'h0E, 1'b0}; // BEQ taken
      vecs[8]  = '{6'h0C, 1'b1, 0, 0, 3, 0, 0, 1, 0, 4'd1, 4'd0, 8'h0E, 1'b0}; // BNE not taken
      vecs[9]  = '{6'h0B, 1'b0, 0, 0, 3, 0, 0, 1, 0, 4'd1, 4'd0, 8'h0E, 1'b0}; // BEQ not taken
      vecs[10] = '{6'h0C, 1'b0, 0, 0, 3, 0, 1, 1, 0, 4'd1, 4'd0, 8'h0E, 1'b0}; // BNE taken
      vecs[11] = '{6'h15, 1'b0, 0, 0, 2, 0, 0, 1, 0, 4'd0, 4'd0, 8'h06, 1'b1}; // illegal 10101
      vecs[12] = '{6'h02, 1'b0, 1, 0, 5, 1, 0, 2, 0, 4'd2, 4'd2, 8'h2E, 1'b0}; // AND
      vecs[13] = '{6'h20, 1'b0, 0, 0, 2, 0, 0, 1, 0, 4'd0, 4'd0, 8'h06, 1'b1}; // upper bit set
      vecs[14] = '{6'h0F, 1'b0, 0, 0, 2, 0, 0, 1, 0, 4'd0, 4'd0, 8'h06, 1'b1}; // 01111
      vecs[15] = '{6'h0D, 1'b0, 0, 0, 3, 0, 0, 1, 0, 4'd0, 4'd0, 8'h0E, 1'b0}; // NOP
      vecs[16] = '{6'h0D, 1'b0, 0, 0, 3, 0, 0, 1, 0, 4'd0, 4'd0, 8'h0E, 1'b0}; // NOP
      vecs[17] = '{6'h08, 1'b0, 1, 0, 6, 1, 0, 3, 0, 4'd0, 4'd0, 8'h3E, 1'b0}; // LOAD
      vecs[18] = '{6'h0E, 1'b0, 0, 0, 2, 0, 0, 1, 0, 4'd0, 4'd0, 8'h06, 1'b0}; // HALT

      rst_n         = 1'b0;
      bus.opcode    = '0;
      bus.zero_flag = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {bus.ir_load, bus.pc_inc, bus.pc_load, bus.mem_req, bus.mem_we,
                            bus.reg_write, bus.retire, bus.halted, bus.illegal, bus.alu_op}, 0);
      chk("reset_state", bus.state, 0);
      chk("reset_instret", bus.instret, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_state", bus.state, 0);
      chk("idle_outputs", {bus.ir_load, bus.pc_inc, bus.mem_req, bus.retire, bus.alu_op}, 0);

      idx      = 0;
      wait_cnt = vecs[0].wf;
      sb_q.push_back(vecs[0]);
      ob       = '{default: 0};
      exp_cnt  = '0;
      ill_seen = 1'b0;

      for (int c = 0; c < 2000 && idx < N; c++) begin
         @(posedge clk);
         #1;
         bus.opcode    = vecs[idx].op;
         bus.zero_flag = vecs[idx].zf;
         bus.mem_ready = (wait_cnt == 0);
         @(negedge clk);
         ob.cyc  += 1;
         ob.rw   += int'(bus.reg_write);
         ob.pcl  += int'(bus.pc_load);
         ob.mreq += int'(bus.mem_req);
         ob.we   += int'(bus.mem_we);
         ob.irl  += int'(bus.ir_load);
         ob.pci  += int'(bus.pc_inc);
         ob.smask[bus.state] = 1'b1;
         if (bus.state == 3'd3) ob.alu_ex = bus.alu_op;
         if (bus.reg_write)     ob.alu_wb = bus.alu_op;
         if (bus.mem_req && !bus.mem_ready && wait_cnt > 0) wait_cnt--;
         if (bus.ir_load) wait_cnt = vecs[idx].wm;
         if (bus.retire) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               ev = sb_q.pop_front();
               chk($sformatf("v%0d_cycles", idx), ob.cyc, ev.cyc);
               chk($sformatf("v%0d_reg_write", idx), ob.rw, ev.rw);
               chk($sformatf("v%0d_pc_load", idx), ob.pcl, ev.pcl);
               chk($sformatf("v%0d_mem_req", idx), ob.mreq, ev.mreq);
               chk($sformatf("v%0d_mem_we", idx), ob.we, ev.we);
               chk($sformatf("v%0d_ir_load", idx), ob.irl, 1);
               chk($sformatf("v%0d_pc_inc", idx), ob.pci, 1);
               chk($sformatf("v%0d_alu_ex", idx), ob.alu_ex, ev.alu_ex);
               chk($sformatf("v%0d_alu_wb", idx), ob.alu_wb, ev.alu_wb);
               chk($sformatf("v%0d_states", idx), ob.smask, ev.smask);
               chk($sformatf("v%0d_illegal", idx), bus.illegal, ill_seen);
               chk($sformatf("v%0d_instret", idx), bus.instret, exp_cnt);
               ill_seen = ill_seen | ev.sets_ill;
            end
            exp_cnt++;
            ob = '{default: 0};
            idx++;
            if (idx < N) begin
               wait_cnt = vecs[idx].wf;
               sb_q.push_back(vecs[idx]);
            end
         end
      end
      if (idx < N) chk("table_timeout_retired", idx, N);

      // HALT must hold regardless of what memory and the IR present.
      bad = 0;
      for (int c = 0; c < 22; c++) begin
         @(posedge clk);
         #1;
         bus.mem_ready = 1'($urandom_range(0, 1));
         bus.opcode    = OW'($urandom);
         @(negedge clk);
         if (!(bus.halted && bus.state == 3'd6 &&
               {bus.ir_load, bus.pc_inc, bus.pc_load, bus.mem_req, bus.mem_we,
                bus.reg_write, bus.retire, bus.alu_op} == '0)) bad++;
      end
      chk("halt_bad_cycles", bad, 0);
      chk("halt_instret_wrapped", bus.instret, exp_cnt);
      chk("illegal_sticky", bus.illegal, 1);

      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_pulse_state", bus.state, 0);
      chk("rst_pulse_instret", bus.instret, 0);
      chk("rst_pulse_illegal", bus.illegal, 0);
      chk("rst_pulse_halted", bus.halted, 0);
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.opcode    = 6'h09;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("idle_after_pulse", bus.state, 0);

      // STORE reaches MEMORY, memory stalls, then reset lands mid-wait.
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(posedge clk);
         #1;
         bus.mem_ready = (bus.state == 3'd1);
         @(negedge clk);
         if (bus.state == 3'd4) found = 1;
      end
      chk("store_reached_memory", found, 1);
      cnt = 0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (bus.state == 3'd4 && bus.mem_req && bus.mem_we) cnt++;
      end
      chk("store_wait_held", cnt, 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_store_mem_req", bus.mem_req, 0);
      chk("rst_mid_store_state", bus.state, 0);
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      cnt           = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cnt += int'(bus.reg_write) + int'(bus.pc_load);
         @(posedge clk);
         #1;
      end
      chk("post_reset_no_rw_pcl", cnt, 0);
      chk("post_reset_store_instret", bus.instret, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
